// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage datapath.
// Handles three things:
//   - redirect flushes for branch, JAL and JALR resolved in MEM;
//   - load-use bubbles with a length set by LU_BUBBLES;
//   - freezing the whole pipe while a data-memory request waits.
// It drives the latch enables and flushes, and keeps saturating event counters.
// The hazard outputs are combinational so the pipeline sees them in the same cycle.
module hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned FLUSH_STAGES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pcsrc_mem,
  input  logic              jal_mem,
  input  logic              jalr_mem,
  input  logic              dmemren_exe,
  input  logic [REG_AW-1:0] rd_exe,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic              dmem_req_mem,
  input  logic              dhit,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              memwb_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              hazard_detected,
  output logic              redirect,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic [CNT_W-1:0]  lu_cnt
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       BUB_INIT    = 2'(LU_BUBBLES - 1);
  localparam logic             MULTI_BUB   = (LU_BUBBLES > 1) ? 1'b1 : 1'b0;
  localparam logic             IDEX_FL_ON  = (FLUSH_STAGES >= 2) ? 1'b1 : 1'b0;
  localparam logic             EXMEM_FL_ON = (FLUSH_STAGES == 3) ? 1'b1 : 1'b0;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      sat_inc = v + CNT_ONE;
    end else begin
      sat_inc = v;
    end
  endfunction

  state_t     state_r, state_nxt_s;
  logic [1:0] bub_r, bub_nxt_s;
  logic       redir_s, freeze_s, lu_s, lu_evt_s;

  // Terms used to classify the current cycle.
  always_comb begin
    redir_s  = pcsrc_mem | jal_mem | jalr_mem;
    freeze_s = dmem_req_mem & ~dhit;
    lu_s     = dmemren_exe & (rd_exe != {REG_AW{1'b0}}) &
               ((use_rs1_id & (rs1_id == rd_exe)) | (use_rs2_id & (rs2_id == rd_exe)));
  end

  // Resolve the cycle by priority: reset, then freeze, then redirect, then load-use.
  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    idex_write      = 1'b1;
    exmem_write     = 1'b1;
    memwb_write     = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    exmem_flush     = 1'b0;
    hazard_detected = 1'b0;
    redirect        = 1'b0;
    lu_evt_s        = 1'b0;
    state_nxt_s     = state_r;
    bub_nxt_s       = bub_r;
    if (RST) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      state_nxt_s = RUN;
      bub_nxt_s   = 2'd0;
    end else if (freeze_s) begin
      // Everything holds, including a redirect that is still waiting in EX/MEM.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (redir_s) begin
      // The flush overrides any load-use stall that is still in progress.
      ifid_flush  = 1'b1;
      idex_flush  = IDEX_FL_ON;
      exmem_flush = EXMEM_FL_ON;
      redirect    = 1'b1;
      state_nxt_s = RUN;
      bub_nxt_s   = 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (lu_s) begin
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            idex_flush      = 1'b1;
            hazard_detected = 1'b1;
            lu_evt_s        = 1'b1;
            if (MULTI_BUB) begin
              state_nxt_s = LU_STALL;
              bub_nxt_s   = BUB_INIT;
            end else begin
              state_nxt_s = RUN;
              bub_nxt_s   = 2'd0;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        LU_STALL: begin
          pc_write        = 1'b0;
          ifid_write      = 1'b0;
          idex_flush      = 1'b1;
          hazard_detected = 1'b1;
          bub_nxt_s       = bub_r - 2'd1;
          if (bub_r == 2'd1) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = LU_STALL;
          end
        end
        default: begin
          state_nxt_s = RUN;
          bub_nxt_s   = 2'd0;
        end
      endcase
    end
  end

  // Stall FSM state and remaining-bubble register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= RUN;
      bub_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      bub_r   <= bub_nxt_s;
    end
  end

  // Saturating performance counters. Reset cycles are never counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt    <= {CNT_W{1'b0}};
      redirect_cnt <= {CNT_W{1'b0}};
      lu_cnt       <= {CNT_W{1'b0}};
    end else begin
      stall_cnt    <= sat_inc(stall_cnt, ~pc_write);
      redirect_cnt <= sat_inc(redirect_cnt, redirect);
      lu_cnt       <= sat_inc(lu_cnt, lu_evt_s);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl. Three differently parametrised copies share one input stream.
// A queue-based scoreboard compares every cycle against a reference model.
// The model tracks a "bubbles still owed" count per copy.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST, pcsrc_mem, jal_mem, jalr_mem, dmemren_exe;
  logic [4:0] rd_exe, rs1_id, rs2_id;
  logic       use_rs1_id, use_rs2_id, dmem_req_mem, dhit;

  // Flag order: pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, hazard, redirect
  logic [9:0]  fl0, fl1, fl2;
  logic [31:0] sc0, rc0, lc0;
  logic [3:0]  sc1, rc1, lc1, sc2, rc2, lc2;

  int LUB[3] = '{1, 3, 2};
  int FSG[3] = '{2, 3, 1};
  int CW[3]  = '{32, 4, 4};

  int tests = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(1), .FLUSH_STAGES(2), .CNT_W(32)) u0 (
    .CLK(CLK), .RST(RST), .pcsrc_mem(pcsrc_mem), .jal_mem(jal_mem), .jalr_mem(jalr_mem),
    .dmemren_exe(dmemren_exe), .rd_exe(rd_exe), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .dmem_req_mem(dmem_req_mem), .dhit(dhit),
    .pc_write(fl0[9]), .ifid_write(fl0[8]), .idex_write(fl0[7]), .exmem_write(fl0[6]),
    .memwb_write(fl0[5]), .ifid_flush(fl0[4]), .idex_flush(fl0[3]), .exmem_flush(fl0[2]),
    .hazard_detected(fl0[1]), .redirect(fl0[0]),
    .stall_cnt(sc0), .redirect_cnt(rc0), .lu_cnt(lc0));

  hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(3), .FLUSH_STAGES(3), .CNT_W(4)) u1 (
    .CLK(CLK), .RST(RST), .pcsrc_mem(pcsrc_mem), .jal_mem(jal_mem), .jalr_mem(jalr_mem),
    .dmemren_exe(dmemren_exe), .rd_exe(rd_exe), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .dmem_req_mem(dmem_req_mem), .dhit(dhit),
    .pc_write(fl1[9]), .ifid_write(fl1[8]), .idex_write(fl1[7]), .exmem_write(fl1[6]),
    .memwb_write(fl1[5]), .ifid_flush(fl1[4]), .idex_flush(fl1[3]), .exmem_flush(fl1[2]),
    .hazard_detected(fl1[1]), .redirect(fl1[0]),
    .stall_cnt(sc1), .redirect_cnt(rc1), .lu_cnt(lc1));

  hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(2), .FLUSH_STAGES(1), .CNT_W(4)) u2 (
    .CLK(CLK), .RST(RST), .pcsrc_mem(pcsrc_mem), .jal_mem(jal_mem), .jalr_mem(jalr_mem),
    .dmemren_exe(dmemren_exe), .rd_exe(rd_exe), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .dmem_req_mem(dmem_req_mem), .dhit(dhit),
    .pc_write(fl2[9]), .ifid_write(fl2[8]), .idex_write(fl2[7]), .exmem_write(fl2[6]),
    .memwb_write(fl2[5]), .ifid_flush(fl2[4]), .idex_flush(fl2[3]), .exmem_flush(fl2[2]),
    .hazard_detected(fl2[1]), .redirect(fl2[0]),
    .stall_cnt(sc2), .redirect_cnt(rc2), .lu_cnt(lc2));

  typedef struct packed {
    logic [2:0][9:0]  fl;
    logic [2:0][31:0] sc;
    logic [2:0][31:0] rc;
    logic [2:0][31:0] lc;
  } exp_t;

  exp_t q[$];

  // Reference model state: bubbles still owed and ideal counter values.
  int     rem[3]  = '{0, 0, 0};
  longint sc_m[3] = '{0, 0, 0};
  longint rc_m[3] = '{0, 0, 0};
  longint lc_m[3] = '{0, 0, 0};

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v < mx) ? v + 1 : v;
  endfunction

  // Drive one cycle of inputs and push the expected behaviour of every copy.
  task automatic cycle(input logic r, input logic p, input logic j, input logic jr,
                       input logic ren, input logic [4:0] rd, input logic [4:0] s1,
                       input logic [4:0] s2, input logic u1_i, input logic u2_i,
                       input logic req, input logic hit);
    exp_t e;
    logic redir, frz, luh;
    logic [9:0] f;
    @(negedge CLK);
    RST = r; pcsrc_mem = p; jal_mem = j; jalr_mem = jr; dmemren_exe = ren;
    rd_exe = rd; rs1_id = s1; rs2_id = s2; use_rs1_id = u1_i; use_rs2_id = u2_i;
    dmem_req_mem = req; dhit = hit;
    redir = p | j | jr;
    frz   = req & ~hit;
    luh   = ren && (rd != 5'd0) && ((u1_i && s1 == rd) || (u2_i && s2 == rd));
    for (int i = 0; i < 3; i++) begin
      e.sc[i] = sc_m[i][31:0];
      e.rc[i] = rc_m[i][31:0];
      e.lc[i] = lc_m[i][31:0];
      if (r) begin
        f = 10'b0000000000;
        rem[i] = 0; sc_m[i] = 0; rc_m[i] = 0; lc_m[i] = 0;
      end else if (frz) begin
        f = 10'b0000000000;
        sc_m[i] = sat(sc_m[i], CW[i]);
      end else if (redir) begin
        f = {6'b111111, (FSG[i] >= 2) ? 1'b1 : 1'b0, (FSG[i] == 3) ? 1'b1 : 1'b0, 2'b01};
        rem[i] = 0;
        rc_m[i] = sat(rc_m[i], CW[i]);
      end else if (rem[i] > 0 || luh) begin
        f = 10'b0011101010;
        if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
        end else begin
          lc_m[i] = sat(lc_m[i], CW[i]);
          rem[i] = LUB[i] - 1;
        end
        sc_m[i] = sat(sc_m[i], CW[i]);
      end else begin
        f = 10'b1111100000;
      end
      e.fl[i] = f;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
                                      1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld_use(input logic [4:0] rd, input logic [4:0] s2, input logic u2_i);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rd, 5'd1, s2, 1'b0, u2_i, 1'b0, 1'b0);
  endtask

  function automatic logic [9:0] act_fl(input int i);
    case (i)
      0:       return fl0;
      1:       return fl1;
      default: return fl2;
    endcase
  endfunction

  function automatic logic [31:0] act_cnt(input int i, input int k);
    case (i * 3 + k)
      0:       return sc0;
      1:       return rc0;
      2:       return lc0;
      3:       return {28'd0, sc1};
      4:       return {28'd0, rc1};
      5:       return {28'd0, lc1};
      6:       return {28'd0, sc2};
      7:       return {28'd0, rc2};
      default: return {28'd0, lc2};
    endcase
  endfunction

  // Monitor: the DUT presents outputs every cycle, so pop and compare after inputs settle.
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (act_fl(i) !== e.fl[i]) begin
          errors++;
          $display("FAIL flags u%0d t=%0t got %b expected %b", i, $time, act_fl(i), e.fl[i]);
        end
        tests++;
        if (act_cnt(i, 0) !== e.sc[i]) begin
          errors++;
          $display("FAIL stall_cnt u%0d t=%0t got %0d expected %0d", i, $time, act_cnt(i, 0), e.sc[i]);
        end
        tests++;
        if (act_cnt(i, 1) !== e.rc[i]) begin
          errors++;
          $display("FAIL redirect_cnt u%0d t=%0t got %0d expected %0d", i, $time, act_cnt(i, 1), e.rc[i]);
        end
        tests++;
        if (act_cnt(i, 2) !== e.lc[i]) begin
          errors++;
          $display("FAIL lu_cnt u%0d t=%0t got %0d expected %0d", i, $time, act_cnt(i, 2), e.lc[i]);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; pcsrc_mem = 1'b0; jal_mem = 1'b0; jalr_mem = 1'b0; dmemren_exe = 1'b0;
    rd_exe = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
    dmem_req_mem = 1'b0; dhit = 1'b0;
    // Reset, then a plain load-use on x5 through rs2.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    ld_use(5'd5, 5'd5, 1'b1);
    idle(4);
    // Non-hazards: the load targets x0, or ID does not read rs2.
    ld_use(5'd0, 5'd0, 1'b1);
    ld_use(5'd5, 5'd5, 1'b0);
    idle(1);
    // Load-use, then a redirect in the second cycle.
    ld_use(5'd7, 5'd7, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Load-use, then four freeze cycles during the bubble.
    ld_use(5'd9, 5'd9, 1'b1);
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // JALR redirect, and a redirect held off by a freeze.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    // Twenty load-use events: the 4-bit counters saturate at 15.
    for (int k = 0; k < 20; k++) begin
      ld_use(5'd3, 5'd3, 1'b1);
      idle(3);
    end
    // Randomised traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)));
    end
    // Reset in the middle of a stall clears everything.
    ld_use(5'd2, 5'd2, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    @(negedge CLK);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the pipeline hazard unit of the 5-stage datapath.
- Combines redirect flushing (branch/JAL/JALR resolved in MEM), load-use bubble insertion with configurable bubble length, and data-memory-wait freezing behind one stall FSM.
- Drives per-latch write enables and flushes for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps saturating performance counters for stall cycles, redirects and load-use events.

Parameters:
- REG_AW, 5: register index width.
- LU_BUBBLES, 1: bubbles inserted per load-use hazard, legal 1..3.
- FLUSH_STAGES, 2: latches cleared on redirect. 1 = IF/ID; 2 = IF/ID and ID/EX; 3 = IF/ID, ID/EX and EX/MEM.
- CNT_W, 32: performance counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- pcsrc_mem  in  1  taken branch in MEM.
- jal_mem  in  1  JAL in MEM.
- jalr_mem  in  1  JALR in MEM.
- dmemren_exe  in  1  load in EX.
- rd_exe  in  REG_AW  destination register of EX.
- rs1_id  in  REG_AW  source 1 of ID.
- rs2_id  in  REG_AW  source 2 of ID.
- use_rs1_id  in  1  ID reads rs1.
- use_rs2_id  in  1  ID reads rs2.
- dmem_req_mem  in  1  MEM has a data request.
- dhit  in  1  data request completes this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID enable.
- idex_write  out  1  ID/EX enable.
- exmem_write  out  1  EX/MEM enable.
- memwb_write  out  1  MEM/WB enable.
- ifid_flush  out  1  IF/ID clear.
- idex_flush  out  1  ID/EX clear.
- exmem_flush  out  1  EX/MEM clear.
- hazard_detected  out  1  load-use bubble this cycle.
- redirect  out  1  redirect flush this cycle.
- stall_cnt  out  CNT_W  cycles with pc_write=0.
- redirect_cnt  out  CNT_W  redirect cycles.
- lu_cnt  out  CNT_W  load-use events.

Behaviour:
- Single clock CLK. Reset RST is synchronous and active-high.
- Derived terms:
  - redir = pcsrc_mem | jal_mem | jalr_mem.
  - freeze = dmem_req_mem & ~dhit.
  - lu = dmemren_exe & (rd_exe != 0) & ((use_rs1_id & rs1_id == rd_exe) | (use_rs2_id & rs2_id == rd_exe)).
- FSM states: RUN, LU_STALL. Down-counter bub_left is 2 bits.
- Outputs are combinational from state and inputs. Priority is freeze > redir > load-use > normal.
- freeze (any state):
  - All five write enables = 0; all flushes = 0; redirect = 0; hazard_detected = 0.
  - State and bub_left hold. A pending redirect stays pending because EX/MEM is held.
- redir (no freeze, any state):
  - pc_write = 1; all write enables = 1.
  - ifid_flush = 1. idex_flush = 1 if FLUSH_STAGES >= 2. exmem_flush = 1 if FLUSH_STAGES == 3.
  - redirect = 1. Next state is RUN and bub_left is cleared, aborting any load-use stall.
- RUN with lu (no freeze/redir):
  - pc_write = 0, ifid_write = 0, idex_flush = 1, other enables = 1, hazard_detected = 1.
  - lu_cnt increments.
  - If LU_BUBBLES > 1: next state LU_STALL, bub_left = LU_BUBBLES-1. Otherwise stay in RUN.
- LU_STALL (no freeze/redir):
  - Same outputs as the RUN-with-lu row, but lu_cnt does not increment.
  - bub_left decrements; when bub_left == 1, next state is RUN.
- RUN with none of the above: all enables = 1, all flushes = 0.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - stall_cnt increments on every non-reset cycle with pc_write = 0.
  - redirect_cnt increments on every cycle with redirect = 1.
- Reset:
  - While RST = 1: all enables = 0, all flushes = 0, hazard_detected = 0, redirect = 0.
  - On the next edge: state RUN, bub_left 0, all counters 0.
  - RST mid-stall aborts the stall. Counters do not count reset cycles.
- Latency: zero-cycle, combinational hazard response. The stall length on a load-use is exactly LU_BUBBLES cycles, excluding freeze cycles.

Test Plan:
- LU_BUBBLES=1, load x5 in EX, ID reads rs2=x5 -> one cycle pc_write=0, idex_flush=1, hazard_detected=1; lu_cnt=1; stall_cnt=1.
- Same hazard but rd_exe=x0, or use_rs2_id=0 -> no stall, all enables 1.
- LU_BUBBLES=3, load-use, then redir asserted during the 2nd bubble -> 2nd cycle shows redirect=1, ifid_flush=1, idex_flush=1, pc_write=1; 3rd cycle normal; stall_cnt=1, redirect_cnt=1.
- LU_BUBBLES=2, load-use, dmem_req_mem=1 with dhit=0 for 4 cycles during the bubble -> all enables 0 for 4 cycles, then the remaining bubble; total stall_cnt=6.
- FLUSH_STAGES=3, jalr_mem=1 -> ifid_flush=idex_flush=exmem_flush=1. With FLUSH_STAGES=1 -> only ifid_flush=1.
- CNT_W=4, force 20 load-use events -> lu_cnt holds at 15. Assert RST -> all counters 0 and outputs are at their reset values.
